bist_response_compactor: RTL
============================

# bist_response_compactor

Downstream response-compaction stage for the 12-input/10-output combinational gate models in the simulator gate library. It captures the 10 gate-model outputs on each valid test pattern and folds them into a 10-bit multiple-input signature register (MISR). After a programmed number of patterns it freezes the signature and compares it against an expected value, so one pass/fail bit replaces cycle-by-cycle output checking.

## Interface
Parameters:
- NUM_PATTERNS, 256: patterns compacted per run, legal range 1..65535.
- SEED, 10'h000: MISR value loaded on start.
- CW, $clog2(NUM_PATTERNS+1): width of the pattern counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a run.
- resp  in  10  gate-model outputs in this bit order, bit 9 down to bit 0: N205, N208, N157, N202, N203, N211, N199, N198, N210, N212.
- resp_valid  in  1  resp holds a settled response for the current pattern.
- exp_sig  in  10  golden signature; sampled in the cycle the final pattern is compacted.
- signature  out  10  current MISR contents.
- count  out  CW  patterns compacted in the current run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  result of the final compare; valid only while done=1.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: signature=SEED, count=0, busy=0, done=0, pass=0.
- MISR polynomial x^10+x^3+1:
  - sig_next[0] = sig[9] ^ resp[0].
  - sig_next[3] = sig[2] ^ sig[9] ^ resp[3].
  - sig_next[i] = sig[i-1] ^ resp[i] for every other i in 1..9.
- IDLE: start → RUN; load signature=SEED, count=0, pass=0. resp_valid is ignored.
- RUN: resp_valid=1 → signature=sig_next and count=count+1. resp_valid=0 → hold.
- RUN, end of run: resp_valid=1 with count==NUM_PATTERNS-1 → DONE; pass=(sig_next==exp_sig).
- DONE: signature, count and pass hold. resp_valid is ignored. start → RUN with a fresh seed.
- start has priority over resp_valid in every state:
  - start in RUN discards the partial run: reseed, count=0, and the coincident resp is not compacted.
  - In DONE, start reseeds and clears pass.
- count never exceeds NUM_PATTERNS and does not wrap.
- NUM_PATTERNS=1: the first valid response both compacts and completes the run.

## Timing
- Fully synchronous apart from the reset.
- start at edge k → busy=1, signature=SEED, count=0 after edge k.
- A response accepted at edge k is visible in signature and count after edge k (1-cycle latency). One response can be accepted per cycle, back-to-back.
- The final accepted response at edge k → busy=0, done=1, and pass valid after edge k, with no extra compare cycle.
- rst_n low forces reset values immediately, independent of clk, including mid-run. Release is synchronised by design: the first active edge after release sees IDLE.

## Test plan
- Reset mid-run: NUM_PATTERNS=4; start, 2 valid responses, then pulse rst_n low between edges → all outputs return to reset values at once; state is IDLE; later resp_valid pulses are ignored.
- Shift path: NUM_PATTERNS=3, SEED=0; start, then resp 0x001, 0x000, 0x000 back-to-back → signature 0x001, 0x002, 0x004; done=1 after the 3rd edge; pass=1 with exp_sig=0x004.
- Feedback tap: SEED=0x200, NUM_PATTERNS=1, resp 0x000 → signature 0x009. With exp_sig=0x008 → pass=0, done=1.
- Gapped valid: NUM_PATTERNS=2; valid responses separated by 5 idle cycles → count steps 0→1→2 only on valid edges; signature matches the gapless result.
- Restart: start in RUN coincident with resp_valid → signature=SEED, count=0, response dropped. start in DONE → done=0, pass=0, busy=1.
- Gate-model integration: drive exhaustive 12-bit inputs 0..4095 into the gate model, NUM_PATTERNS=4096 → signature equals the bench's reference-model MISR and pass=1.

Source files
------------

// File: rtl/bist_response_compactor.sv
// -----------------------------------------------------------------------------
// bist_response_compactor
//
// Compacts the 10 outputs of a 12-input/10-output gate model into a 10-bit
// multiple-input signature register (MISR, polynomial x^10 + x^3 + 1). A run
// is started with a one-cycle start pulse, compacts NUM_PATTERNS valid
// responses, then freezes the signature and compares it against exp_sig.
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   one-cycle pulse, begins or restarts a run
//   resp       in  10   gate-model outputs, bit 9..0 =
//                       N205 N208 N157 N202 N203 N211 N199 N198 N210 N212
//   resp_valid in   1   resp holds a settled response for this pattern
//   exp_sig    in  10   golden signature, sampled with the final response
//   signature  out 10   current MISR contents
//   count      out CW   patterns compacted in the current run
//   busy       out  1   high while a run is in progress (RUN)
//   done       out  1   high once the run completed (DONE)
//   pass       out  1   final compare result, valid while done=1
//
// Handshake: a response is accepted on every rising edge where the block is
// in RUN, resp_valid=1 and start=0. There is no back-pressure; one response
// per cycle can be accepted back-to-back. start always wins over resp_valid.
//
// FSM state is observable through busy/done: IDLE = 00, RUN = 10, DONE = 01.
// -----------------------------------------------------------------------------
module bist_response_compactor #(
    parameter int          NUM_PATTERNS = 256,
    parameter logic [9:0]  SEED         = 10'h000,
    parameter int          CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [9:0]    resp,
    input  logic          resp_valid,
    input  logic [9:0]    exp_sig,
    output logic [9:0]    signature,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [9:0] sig_next;
    logic       last;

    // Rotate left gives bit0 <= sig[9] and bit i <= sig[i-1]; bit 3 then
    // additionally takes the x^3 feedback tap from sig[9].
    always_comb begin
        sig_next    = {signature[8:0], signature[9]} ^ resp;
        sig_next[3] = signature[2] ^ signature[9] ^ resp[3];
    end

    // The response being accepted now is the final one of the run.
    assign last = (count == CW'(NUM_PATTERNS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            signature <= SEED;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else if (start) begin
            // Restart from any state; a coincident response is dropped.
            state     <= RUN;
            signature <= SEED;
            count     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (resp_valid) begin
                        signature <= sig_next;
                        count     <= count + CW'(1);
                        if (last) begin
                            // Compare against the value being loaded, so the
                            // result is ready on the same edge as done.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_next == exp_sig);
                        end
                    end
                end
                IDLE: begin
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
